// File: rtl/fpdiv_pkg.sv
// Shared definitions for the sequential single-precision divide front end.
//   - exc_e   : 2-bit result exception code reported on EXCEPTION
//   - state_e : control FSM encoding (also visible on the STATE debug output)
//   - IEEE-754 constants and small result-building helpers
package fpdiv_pkg;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_DIVZERO = 2'b01,
    EXC_INVALID = 2'b10,
    EXC_RANGE   = 2'b11
  } exc_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CLASSIFY = 2'b01,
    ST_WAIT     = 2'b10
  } state_e;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  function automatic logic [31:0] signed_inf(input logic s);
    return {s, POS_INF[30:0]};
  endfunction

  function automatic logic [31:0] signed_zero(input logic s);
    return {s, 31'b0};
  endfunction

endpackage

// File: rtl/divider.sv
// Combinational single-precision divide core for normal operands.
// The result is rounded to nearest-even; exponent overflow gives signed
// infinity and exponent underflow gives signed zero. Special operands are
// screened out upstream, so their output here is don't-care.
//   a_i : dividend
//   b_i : divisor
//   q_o : quotient
module divider (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] q_o
);

  logic [23:0]        man_a;
  logic [23:0]        man_b;
  logic [49:0]        num;
  logic [26:0]        quo;
  logic [23:0]        rem;
  logic               norm_hi;
  logic [23:0]        man;
  logic               guard;
  logic               sticky;
  logic               round_up;
  logic [24:0]        man_r;
  logic [22:0]        frac;
  logic signed [9:0]  exp_r;
  logic               sign;

  always_comb begin
    sign  = a_i[31] ^ b_i[31];
    man_a = {1'b1, a_i[22:0]};
    man_b = {1'b1, b_i[22:0]};
    // Mantissa ratio lies in (0.5, 2): 26 fractional quotient bits leave
    // 24 significant bits plus guard after normalisation either way.
    num   = {man_a, 26'b0};
    quo   = 27'(num / {26'b0, man_b});
    rem   = 24'(num % {26'b0, man_b});

    norm_hi = quo[26];
    if (norm_hi) begin
      man    = quo[26:3];
      guard  = quo[2];
      sticky = (|quo[1:0]) | (|rem);
    end else begin
      man    = quo[25:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
    end

    round_up = guard & (sticky | man[0]);
    man_r    = {1'b0, man} + {24'b0, round_up};
    // A rounding carry leaves man_r = 2^24 exactly, so [23:1] is all zero.
    frac     = man_r[24] ? man_r[23:1] : man_r[22:0];

    exp_r = $signed({2'b00, a_i[30:23]}) - $signed({2'b00, b_i[30:23]})
          + 10'sd127
          - (norm_hi   ? 10'sd0 : 10'sd1)
          + (man_r[24] ? 10'sd1 : 10'sd0);

    if (exp_r > 10'sd254) begin
      q_o = {sign, 8'hFF, 23'b0};
    end else if (exp_r < 10'sd1) begin
      q_o = {sign, 31'b0};
    end else begin
      q_o = {sign, exp_r[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754 single-precision operand.
// Denormals (exponent 0) are flushed: they report is_zero_o with their sign.
//   op_i      : operand
//   is_zero_o : +/-0 or any denormal
//   is_inf_o  : +/-infinity
//   is_nan_o  : any NaN (quiet or signalling)
//   sign_o    : sign bit
//   exp_o     : biased exponent field
module fp_classify
  import fpdiv_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        is_zero_o,
  output logic        is_inf_o,
  output logic        is_nan_o,
  output logic        sign_o,
  output logic [7:0]  exp_o
);

  logic frac_nz;

  assign frac_nz   = |op_i[22:0];
  assign sign_o    = op_i[31];
  assign exp_o     = op_i[30:23];
  assign is_zero_o = (op_i[30:23] == 8'h00);
  assign is_inf_o  = (op_i[30:23] == EXP_MAX) && !frac_nz;
  assign is_nan_o  = (op_i[30:23] == EXP_MAX) && frac_nz;

endmodule

// File: rtl/fpdiv_seq.sv
// Sequential front end for the single-precision divide path.
// Captures operands on START, resolves special operands and exponent range
// in one CLASSIFY cycle, otherwise lets the combinational divider settle for
// SETTLE_CYCLES cycles before registering its output.
//
// Handshake: START is sampled only while IDLE; a START seen in any other
// state is dropped. Each result load raises DONE for exactly one cycle, in
// which the FSM is already IDLE and can accept the next START.
//
//   CLOCK     : clock, rising edge
//   RESET     : asynchronous active-high reset
//   START     : request a divide
//   InputA/B  : dividend / divisor (IEEE-754 single)
//   AbyB      : registered quotient, held until the next result load
//   DONE      : one-cycle pulse on each result load
//   BUSY      : high while the FSM is not IDLE
//   EXCEPTION : 00 none, 01 divide by zero, 10 invalid, 11 over/underflow
//   STATE     : current FSM state (debug)
module fpdiv_seq
  import fpdiv_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        START,
  input  logic [31:0] InputA,
  input  logic [31:0] InputB,
  output logic [31:0] AbyB,
  output logic        DONE,
  output logic        BUSY,
  output logic [1:0]  EXCEPTION,
  output logic [1:0]  STATE
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] quot_q, quot_d;
  logic [1:0]  exc_q, exc_d;
  logic        done_q, done_d;

  logic        a_zero, a_inf, a_nan, a_sign;
  logic        b_zero, b_inf, b_nan, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic        res_sign;
  logic        invalid;
  logic        divzero;
  logic signed [9:0] e_pred;
  logic [31:0] core_q;

  fp_classify u_cls_a (
    .op_i      (op_a_q),
    .is_zero_o (a_zero),
    .is_inf_o  (a_inf),
    .is_nan_o  (a_nan),
    .sign_o    (a_sign),
    .exp_o     (a_exp)
  );

  fp_classify u_cls_b (
    .op_i      (op_b_q),
    .is_zero_o (b_zero),
    .is_inf_o  (b_inf),
    .is_nan_o  (b_nan),
    .sign_o    (b_sign),
    .exp_o     (b_exp)
  );

  // Fed only from the operand registers so the settle window is not
  // disturbed by activity on the input ports.
  divider u_divider (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .q_o (core_q)
  );

  assign res_sign = a_sign ^ b_sign;
  assign invalid  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign divzero  = !a_inf & !a_zero & b_zero;
  assign e_pred   = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                  + $signed(10'(EXP_BIAS));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    quot_d  = quot_q;
    exc_d   = exc_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          op_a_d  = InputA;
          op_b_d  = InputB;
          state_d = ST_CLASSIFY;
        end
      end

      ST_CLASSIFY: begin
        // Branch order is the priority: NaN/indeterminate first, then x/0,
        // then infinite dividend, then zero quotient, then exponent range.
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (invalid) begin
          quot_d = QNAN;
          exc_d  = EXC_INVALID;
        end else if (divzero) begin
          quot_d = signed_inf(res_sign);
          exc_d  = EXC_DIVZERO;
        end else if (a_inf) begin
          quot_d = signed_inf(res_sign);
          exc_d  = EXC_NONE;
        end else if (a_zero || b_inf) begin
          quot_d = signed_zero(res_sign);
          exc_d  = EXC_NONE;
        end else if (e_pred > 10'sd254) begin
          quot_d = signed_inf(res_sign);
          exc_d  = EXC_RANGE;
        end else if (e_pred < 10'sd1) begin
          quot_d = signed_zero(res_sign);
          exc_d  = EXC_RANGE;
        end else begin
          state_d = ST_WAIT;
          done_d  = 1'b0;
          cnt_d   = 4'd0;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          quot_d  = core_q;
          exc_d   = EXC_NONE;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      quot_q  <= 32'd0;
      exc_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      quot_q  <= quot_d;
      exc_q   <= exc_d;
      done_q  <= done_d;
    end
  end

  assign AbyB      = quot_q;
  assign EXCEPTION = exc_q;
  assign DONE      = done_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign STATE     = state_q;

endmodule

// File: tb/tb_fpdiv_seq.sv
module tb_fpdiv_seq;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        START;
  logic [31:0] InputA;
  logic [31:0] InputB;
  logic [31:0] AbyB;
  logic        DONE;
  logic        BUSY;
  logic [1:0]  EXCEPTION;
  logic [1:0]  STATE;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_CLASSIFY = 2'd1;
  localparam logic [1:0] S_WAIT     = 2'd2;

  // Normal operands: quotient after 5 edges, BUSY for 5 samples.
  localparam int NN = 7;
  localparam logic [31:0] N_A [NN] = '{32'h40C00000, 32'h3F800000, 32'h40400000,
                                       32'h40000000, 32'hC0C00000, 32'h7F000000,
                                       32'h00800000};
  localparam logic [31:0] N_B [NN] = '{32'h40000000, 32'h40000000, 32'h40000000,
                                       32'h40400000, 32'h40000000, 32'h3F800000,
                                       32'h3F800000};
  localparam logic [31:0] N_Q [NN] = '{32'h40400000, 32'h3F000000, 32'h3FC00000,
                                       32'h3F2AAAAB, 32'hC0400000, 32'h7F000000,
                                       32'h00800000};

  // Special operands: divide by zero, invalid, infinite / zero quotients.
  localparam int NS = 12;
  localparam logic [31:0] S_A [NS] = '{32'h3F800000, 32'hBF800000, 32'h3F800000,
                                       32'h00000000, 32'h7F800000, 32'h7FC00001,
                                       32'h3F800000, 32'h7F800000, 32'h7F800000,
                                       32'h80000000, 32'h3F800000, 32'h00000001};
  localparam logic [31:0] S_B [NS] = '{32'h00000000, 32'h00000000, 32'h00000001,
                                       32'h00000000, 32'hFF800000, 32'h3F800000,
                                       32'h7F800001, 32'hC0000000, 32'h00000000,
                                       32'h40000000, 32'hFF800000, 32'h3F800000};
  localparam logic [31:0] S_Q [NS] = '{32'h7F800000, 32'hFF800000, 32'h7F800000,
                                       32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                       32'h7FC00000, 32'hFF800000, 32'h7F800000,
                                       32'h80000000, 32'h80000000, 32'h00000000};
  localparam logic [1:0]  S_E [NS] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
                                       2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

  // Exponent out of range: overflow / underflow at 1-edge latency.
  localparam int NR = 5;
  localparam logic [31:0] R_A [NR] = '{32'h7F000000, 32'h00800000, 32'hFF000000,
                                       32'h7F000000, 32'h00800000};
  localparam logic [31:0] R_B [NR] = '{32'h3E800000, 32'h7E800000, 32'h3E800000,
                                       32'h3F000000, 32'h40000000};
  localparam logic [31:0] R_Q [NR] = '{32'h7F800000, 32'h00000000, 32'hFF800000,
                                       32'h7F800000, 32'h00000000};

  fpdiv_seq #(.SETTLE_CYCLES(4)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .START     (START),
    .InputA    (InputA),
    .InputB    (InputB),
    .AbyB      (AbyB),
    .DONE      (DONE),
    .BUSY      (BUSY),
    .EXCEPTION (EXCEPTION),
    .STATE     (STATE)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  // Issue one START and wait (bounded) for DONE. lat counts edges after the
  // START edge; busy_n counts BUSY samples taken before DONE.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [1:0] exc,
                        output int lat, output int busy_n);
    InputA = a;
    InputB = b;
    START  = 1'b1;
    step();
    START  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) busy_n++;
      step();
      lat++;
    end
    q   = AbyB;
    exc = EXCEPTION;
  endtask

  task automatic test_reset();
    RESET  = 1'b1;
    START  = 1'b0;
    InputA = 32'h0;
    InputB = 32'h0;
    step();
    step();
    checks++; if (AbyB !== 32'h0)      begin errors++; $display("FAIL reset_abyb got %h exp 00000000", AbyB); end
    checks++; if (EXCEPTION !== 2'b00) begin errors++; $display("FAIL reset_exc got %b exp 00", EXCEPTION); end
    checks++; if (DONE !== 1'b0)       begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
    checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (STATE !== S_IDLE)    begin errors++; $display("FAIL reset_state got %0d exp %0d", STATE, S_IDLE); end
    RESET = 1'b0;
    step();
  endtask

  task automatic test_normal();
    logic [31:0] q;
    logic [1:0]  exc;
    int          lat;
    int          busy_n;
    for (int i = 0; i < NN; i++) begin
      do_div(N_A[i], N_B[i], q, exc, lat, busy_n);
      checks++; if (q !== N_Q[i])  begin errors++; $display("FAIL normal_q[%0d] got %h exp %h", i, q, N_Q[i]); end
      checks++; if (exc !== 2'b00) begin errors++; $display("FAIL normal_exc[%0d] got %b exp 00", i, exc); end
      checks++; if (lat != 5)      begin errors++; $display("FAIL normal_lat[%0d] got %0d exp 5", i, lat); end
      checks++; if (busy_n != 5)   begin errors++; $display("FAIL normal_busy[%0d] got %0d exp 5", i, busy_n); end
      step();
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL normal_pulse[%0d] got %b exp 0", i, DONE); end
      checks++; if (AbyB !== N_Q[i]) begin errors++; $display("FAIL normal_hold[%0d] got %h exp %h", i, AbyB, N_Q[i]); end
    end
  endtask

  task automatic test_special();
    logic [31:0] q;
    logic [1:0]  exc;
    int          lat;
    int          busy_n;
    for (int i = 0; i < NS; i++) begin
      do_div(S_A[i], S_B[i], q, exc, lat, busy_n);
      checks++; if (q !== S_Q[i])   begin errors++; $display("FAIL special_q[%0d] got %h exp %h", i, q, S_Q[i]); end
      checks++; if (exc !== S_E[i]) begin errors++; $display("FAIL special_exc[%0d] got %b exp %b", i, exc, S_E[i]); end
      checks++; if (lat != 1)       begin errors++; $display("FAIL special_lat[%0d] got %0d exp 1", i, lat); end
      checks++; if (busy_n != 1)    begin errors++; $display("FAIL special_busy[%0d] got %0d exp 1", i, busy_n); end
    end
  endtask

  task automatic test_range();
    logic [31:0] q;
    logic [1:0]  exc;
    int          lat;
    int          busy_n;
    for (int i = 0; i < NR; i++) begin
      do_div(R_A[i], R_B[i], q, exc, lat, busy_n);
      checks++; if (q !== R_Q[i])  begin errors++; $display("FAIL range_q[%0d] got %h exp %h", i, q, R_Q[i]); end
      checks++; if (exc !== 2'b11) begin errors++; $display("FAIL range_exc[%0d] got %b exp 11", i, exc); end
      checks++; if (lat != 1)      begin errors++; $display("FAIL range_lat[%0d] got %0d exp 1", i, lat); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    InputA = 32'h40C00000;
    InputB = 32'h40000000;
    START  = 1'b1;
    step();
    START  = 1'b0;
    step();
    step();
    checks++; if (STATE !== S_WAIT) begin errors++; $display("FAIL b2b_wait_state got %0d exp %0d", STATE, S_WAIT); end
    // New operands with START held from inside WAIT through the DONE cycle.
    InputA = 32'h40400000;
    InputB = 32'h40000000;
    START  = 1'b1;
    lat    = 2;
    while (!DONE && lat < 40) begin
      step();
      lat++;
    end
    checks++; if (lat != 5)             begin errors++; $display("FAIL b2b_first_lat got %0d exp 5", lat); end
    checks++; if (AbyB !== 32'h40400000) begin errors++; $display("FAIL b2b_first_q got %h exp 40400000", AbyB); end
    checks++; if (EXCEPTION !== 2'b00)  begin errors++; $display("FAIL b2b_first_exc got %b exp 00", EXCEPTION); end
    step();
    START = 1'b0;
    checks++; if (STATE !== S_CLASSIFY) begin errors++; $display("FAIL b2b_relaunch got %0d exp %0d", STATE, S_CLASSIFY); end
    lat = 0;
    while (!DONE && lat < 40) begin
      step();
      lat++;
    end
    checks++; if (lat != 5)             begin errors++; $display("FAIL b2b_second_lat got %0d exp 5", lat); end
    checks++; if (AbyB !== 32'h3FC00000) begin errors++; $display("FAIL b2b_second_q got %h exp 3FC00000", AbyB); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    logic [1:0]  exc;
    int          lat;
    int          busy_n;
    int          done_n;
    InputA = 32'h40C00000;
    InputB = 32'h40000000;
    START  = 1'b1;
    step();
    START  = 1'b0;
    step();
    step();
    RESET = 1'b1;
    #1;
    checks++; if (AbyB !== 32'h0)      begin errors++; $display("FAIL midrst_abyb got %h exp 00000000", AbyB); end
    checks++; if (EXCEPTION !== 2'b00) begin errors++; $display("FAIL midrst_exc got %b exp 00", EXCEPTION); end
    checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b exp 0", BUSY); end
    checks++; if (STATE !== S_IDLE)    begin errors++; $display("FAIL midrst_state got %0d exp %0d", STATE, S_IDLE); end
    step();
    RESET  = 1'b0;
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (DONE) done_n++;
    end
    checks++; if (done_n != 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", done_n); end
    do_div(32'h3F800000, 32'h40000000, q, exc, lat, busy_n);
    checks++; if (q !== 32'h3F000000) begin errors++; $display("FAIL midrst_after_q got %h exp 3F000000", q); end
    checks++; if (lat != 5)           begin errors++; $display("FAIL midrst_after_lat got %0d exp 5", lat); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
